sdram_port_mux: RTL and testbench

SDRAM_PORT_MUX -- requirements
Module: sdram_port_mux

---
 rtl/sdram_port_mux.sv | 133 +++++++++++++
 tb/tb_sdram_port_mux.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_mux.sv
// Two-port slot-synchronous arbiter in front of a single SDRAM controller port.
// Optional macro SDRAM_PORT_MUX_FAIR_EN: round-robin arbitration on simultaneous requests.
module sdram_port_mux #(
  parameter int AW = 25,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clkref,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_oe,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

  state_t        state_q;
  logic          clkref_q;
  logic          slot_start;
  logic          any_req;
  logic          grant_q;
  logic          grant_d;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic          mem_oe_q;
  logic          mem_we_q;
  logic          p0_ack_q;
  logic          p1_ack_q;
  logic [DW-1:0] p0_rdata_q;
  logic [DW-1:0] p1_rdata_q;

  // clkref is sampled without reset so a level held high through reset
  // never looks like a fresh edge once reset is released.
  always_ff @(posedge clk) begin
    clkref_q <= clkref;
  end

  assign slot_start = clkref & ~clkref_q;
  assign any_req    = p0_req | p1_req;

`ifdef SDRAM_PORT_MUX_FAIR_EN
  logic p0_last_q;  // 1 when port 0 received the most recent grant

  assign grant_d = (p0_req && p1_req) ? p0_last_q : ~p0_req;
`else
  assign grant_d = ~p0_req;
`endif

  assign sel_we    = grant_d ? p1_we    : p0_we;
  assign sel_addr  = grant_d ? p1_addr  : p0_addr;
  assign sel_wdata = grant_d ? p1_wdata : p0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifdef SDRAM_PORT_MUX_FAIR_EN
      p0_last_q  <= 1'b0;
`endif
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      if (slot_start) begin
        case (state_q)
          ACCESS: begin
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= GAP;
            if (grant_q) begin
              p1_ack_q <= 1'b1;
              if (mem_oe_q) p1_rdata_q <= mem_dout;
            end else begin
              p0_ack_q <= 1'b1;
              if (mem_oe_q) p0_rdata_q <= mem_dout;
            end
          end
          default: begin
            if (any_req) begin
              grant_q    <= grant_d;
              mem_addr_q <= sel_addr;
              mem_din_q  <= sel_wdata;
              mem_we_q   <= sel_we;
              mem_oe_q   <= ~sel_we;
              state_q    <= ACCESS;
`ifdef SDRAM_PORT_MUX_FAIR_EN
              p0_last_q  <= ~grant_d;
`endif
            end else begin
              mem_oe_q <= 1'b0;
              mem_we_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_oe   = mem_oe_q;
  assign mem_we   = mem_we_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sdram_port_mux.sv
// Self-checking bench for sdram_port_mux against a slot-level reference model.
module tb_sdram_port_mux;
  localparam int AW   = 25;
  localparam int DW   = 8;
  localparam int SLOT = 6;
  localparam int VW   = 4 + AW + 3 * DW;
`ifdef SDRAM_PORT_MUX_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clkref;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_oe, mem_we;
  logic [DW-1:0] mem_dout;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  sdram_port_mux #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .clkref(clkref),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Slot reference: high for half of every SLOT-cycle period, changed on negedge.
  initial begin
    clkref = 1'b0;
    forever begin
      @(negedge clk);
      phase  = (phase + 1) % SLOT;
      clkref = (phase < SLOT / 2);
    end
  end

  // Slot-level reference: an access is either in flight or not; at each slot
  // start an in-flight access completes, otherwise a pending request is granted.
  logic          m_prev = 1'b0;
  logic          m_ss, m_busy, m_we, m_port, m_last, m_ack0, m_ack1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_rd0, m_rd1;

  always @(posedge clk) begin
    m_ss   = clkref & ~m_prev;
    m_prev = clkref;
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_we = 1'b0; m_port = 1'b0; m_last = 1'b1;
      m_addr = '0; m_din = '0; m_rd0 = '0; m_rd1 = '0;
    end else if (m_ss) begin
      if (m_busy) begin
        if (m_port) begin
          m_ack1 = 1'b1;
          if (!m_we) m_rd1 = mem_dout;
        end else begin
          m_ack0 = 1'b1;
          if (!m_we) m_rd0 = mem_dout;
        end
        m_busy = 1'b0;
      end else if (p0_req || p1_req) begin
        if (p0_req && p1_req) m_port = FAIR ? ~m_last : 1'b0;
        else                  m_port = p1_req;
        m_we   = m_port ? p1_we    : p0_we;
        m_addr = m_port ? p1_addr  : p0_addr;
        m_din  = m_port ? p1_wdata : p0_wdata;
        m_last = m_port;
        m_busy = 1'b1;
      end
    end
  end

  logic [VW-1:0] obs_vec, exp_vec;
  assign obs_vec = {mem_oe, mem_we, mem_addr, mem_din, p0_ack, p1_ack, p0_rdata, p1_rdata};
  assign exp_vec = {m_busy & ~m_we, m_busy & m_we, m_addr, m_din, m_ack0, m_ack1, m_rd0, m_rd1};

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== '0) begin
      errors++;
      $display("FAIL reset_state obs=%h exp=0", obs_vec);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int  oe_cycles = 0;
    int  guard = 0;
    bit  done = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 25'h0001234; p1_wdata = 8'h77; mem_dout = 8'h00;
    while (!done && guard < 4 * SLOT) begin
      @(negedge clk);
      guard++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rd_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      if (mem_oe) begin
        oe_cycles++;
        mem_dout = 8'h5A;
        checks++;
        if (mem_addr !== 25'h0001234) begin
          errors++;
          $display("FAIL rd_addr obs=%h exp=0001234", mem_addr);
        end
      end
      if (p1_ack) begin
        done = 1'b1;
        p1_req = 1'b0;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL rd_timeout obs=no_ack exp=p1_ack"); end
    checks++;
    if (oe_cycles != SLOT) begin errors++; $display("FAIL rd_oe_len obs=%0d exp=%0d", oe_cycles, SLOT); end
    checks++;
    if (p1_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data obs=%h exp=5a", p1_rdata); end
  endtask

  task automatic test_single_write();
    int we_cycles = 0;
    int guard = 0;
    bit done = 1'b0;
    bit saw_oe = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h1000000; p0_wdata = 8'hC3; mem_dout = 8'hEE;
    while (!done && guard < 4 * SLOT) begin
      @(negedge clk);
      guard++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL wr_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      if (mem_oe) saw_oe = 1'b1;
      if (mem_we) begin
        we_cycles++;
        checks++;
        if (mem_din !== 8'hC3 || mem_addr !== 25'h1000000) begin
          errors++;
          $display("FAIL wr_bus obs=%h/%h exp=1000000/c3", mem_addr, mem_din);
        end
      end
      if (p0_ack) begin
        done = 1'b1;
        p0_req = 1'b0;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL wr_timeout obs=no_ack exp=p0_ack"); end
    checks++;
    if (we_cycles != SLOT || saw_oe) begin
      errors++;
      $display("FAIL wr_we_len obs=%0d oe=%0b exp=%0d oe=0", we_cycles, saw_oe, SLOT);
    end
    checks++;
    if (p0_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata obs=%h exp=00", p0_rdata); end
  endtask

  task automatic test_back_to_back();
    int acts[$];
    int ack_slots[$];
    int slot = 0;
    int guard = 0;
    bit started = 1'b0;
    int pat[5] = '{1, 0, 1, 0, 1};
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 25'h0000042;
    while (ack_slots.size() < 3 && guard < 12 * SLOT) begin
      @(negedge clk);
      guard++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      if (m_ss) begin
        slot++;
        if (mem_oe || mem_we) started = 1'b1;
        if (started) acts.push_back(int'(mem_oe | mem_we));
        if (p0_ack) ack_slots.push_back(slot);
      end
      mem_dout = 8'($urandom);
    end
    p0_req = 1'b0;
    checks++;
    if (ack_slots.size() != 3 || acts.size() < 5) begin
      errors++;
      $display("FAIL b2b_count obs=%0d acks exp=3", ack_slots.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (acts[i] != pat[i]) begin
          errors++;
          $display("FAIL b2b_pattern slot%0d obs=%0d exp=%0d", i, acts[i], pat[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (ack_slots[i] - ack_slots[i-1] != 2) begin
          errors++;
          $display("FAIL b2b_spacing obs=%0d exp=2", ack_slots[i] - ack_slots[i-1]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int order[$];
    int guard = 0;
    int exp_order[4];
    for (int i = 0; i < 4; i++) exp_order[i] = FAIR ? (i % 2) : 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h0000100; p0_wdata = 8'h11;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 25'h0000200; p1_wdata = 8'h22;
    while (order.size() < 4 && guard < 16 * SLOT) begin
      @(negedge clk);
      guard++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL cont_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      if (p0_ack) order.push_back(0);
      if (p1_ack) order.push_back(1);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL cont_count obs=%0d exp=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL cont_order idx%0d obs=%0d exp=%0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int guard = 0;
    int acks = 0;
    bit regrant = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 25'h0ABCDEF;
    while (!(mem_oe || mem_we) && guard < 4 * SLOT) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!mem_oe) begin errors++; $display("FAIL rst_mid_grant obs=%0b exp=1", mem_oe); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_oe !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear obs=%0b%0b exp=00", mem_oe, mem_we);
    end
    @(negedge clk);
    reset = 1'b0;
    guard = 0;
    while (!regrant && guard < 4 * SLOT) begin
      @(negedge clk);
      guard++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rst_mid_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      if (p0_ack || p1_ack) acks++;
      if (mem_oe) begin
        regrant = 1'b1;
        checks++;
        if (!m_ss) begin errors++; $display("FAIL rst_mid_slot obs=mid_slot exp=slot_start"); end
      end
    end
    checks++;
    if (!regrant || acks != 0) begin
      errors++;
      $display("FAIL rst_mid_regrant obs=grant%0b acks%0d exp=grant1 acks0", regrant, acks);
    end
    guard = 0;
    while (!p1_ack && guard < 2 * SLOT) begin
      @(negedge clk);
      guard++;
    end
    p1_req = 1'b0;
  endtask

  task automatic test_withdraw();
    int guard = 0;
    int bad = 0;
    while (!(m_ss && !mem_oe && !mem_we && !m_busy) && guard < 6 * SLOT) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 6 * SLOT) begin errors++; $display("FAIL wd_sync obs=timeout exp=idle_slot"); end
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 25'h0000555;
    repeat (2) @(negedge clk);
    p1_req = 1'b0;
    for (int c = 0; c < 2 * SLOT; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL wd_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      if (mem_oe || mem_we || p1_ack) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wd_activity obs=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rnd_cycle t=%0t obs=%h exp=%h", $time, obs_vec, exp_vec);
      end
      checks++;
      if ((mem_oe && mem_we) || (p0_ack && p1_ack)) begin
        errors++;
        $display("FAIL rnd_exclusive obs=%0b%0b%0b%0b exp=no_overlap", mem_oe, mem_we, p0_ack, p1_ack);
      end
      mem_dout = 8'($urandom);
      if (p0_ack)       p0_req = 1'($urandom);
      else if (!p0_req) p0_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 15) == 0) p0_req = 1'b0;
      if (p1_ack)       p1_req = 1'($urandom);
      else if (!p1_req) p1_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 15) == 0) p1_req = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        p0_we = 1'($urandom); p0_addr = AW'($urandom); p0_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        p1_we = 1'($urandom); p1_addr = AW'($urandom); p1_wdata = 8'($urandom);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    mem_dout = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_contention();
    test_reset_mid_access();
    test_withdraw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
